// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS pipe.
// Optional macro IDEX_STALL_COUNT_EN adds a 32-bit StallCount output.
//
// Ports:
//   CLK, Reset           clock (rising edge), async active-high reset
//   *D inputs            decode control bundle, register data, fields, imm, PC+4
//   FlushE               squash the instruction entering EX (taken branch)
//   *E outputs           registered copy of the decode bundle
//   ValidE               EX holds a real instruction (0 = bubble)
//   StallF, StallD       hold PC / IF-ID register during a load-use stall
//   StallCount           (IDEX_STALL_COUNT_EN only) number of load-use stalls

module id_ex_stage_reg #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          CLK,
    input  logic          Reset,

    input  logic          RegWriteD,
    input  logic          MemtoRegD,
    input  logic          MemWriteD,
    input  logic          BranchD,
    input  logic [3:0]    ALUControlD,
    input  logic          ALUSrcD,
    input  logic          ALUSrc_shamtD,
    input  logic          RegDstD,
    input  logic [DW-1:0] RD1D,
    input  logic [DW-1:0] RD2D,
    input  logic [RW-1:0] RsD,
    input  logic [RW-1:0] RtD,
    input  logic [RW-1:0] RdD,
    input  logic [RW-1:0] ShamtD,
    input  logic [DW-1:0] SignImmD,
    input  logic [DW-1:0] PCPlus4D,

    input  logic          FlushE,

    output logic          RegWriteE,
    output logic          MemtoRegE,
    output logic          MemWriteE,
    output logic          BranchE,
    output logic [3:0]    ALUControlE,
    output logic          ALUSrcE,
    output logic          ALUSrc_shamtE,
    output logic          RegDstE,
    output logic [DW-1:0] RD1E,
    output logic [DW-1:0] RD2E,
    output logic [RW-1:0] RsE,
    output logic [RW-1:0] RtE,
    output logic [RW-1:0] RdE,
    output logic [RW-1:0] ShamtE,
    output logic [DW-1:0] SignImmE,
    output logic [DW-1:0] PCPlus4E,
    output logic          ValidE,
`ifdef IDEX_STALL_COUNT_EN
    output logic [31:0]   StallCount,
`endif
    output logic          StallF,
    output logic          StallD
);

    typedef struct packed {
        logic          regwrite;
        logic          memtoreg;
        logic          memwrite;
        logic          branch;
        logic [3:0]    alucontrol;
        logic          alusrc;
        logic          alusrc_shamt;
        logic          regdst;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [RW-1:0] shamt;
        logic [DW-1:0] signimm;
        logic [DW-1:0] pcplus4;
        logic          valid;
    } ex_bundle_t;

    ex_bundle_t d_bundle;
    ex_bundle_t e_d;
    ex_bundle_t e_q;

    logic rt_hit;
    logic lwstall;
    logic bubble;

    // Decode-side bundle as it would enter EX on a normal capture.
    always_comb begin
        d_bundle              = '0;
        d_bundle.regwrite     = RegWriteD;
        d_bundle.memtoreg     = MemtoRegD;
        d_bundle.memwrite     = MemWriteD;
        d_bundle.branch       = BranchD;
        d_bundle.alucontrol   = ALUControlD;
        d_bundle.alusrc       = ALUSrcD;
        d_bundle.alusrc_shamt = ALUSrc_shamtD;
        d_bundle.regdst       = RegDstD;
        d_bundle.rd1          = RD1D;
        d_bundle.rd2          = RD2D;
        d_bundle.rs           = RsD;
        d_bundle.rt           = RtD;
        d_bundle.rd           = RdD;
        d_bundle.shamt        = ShamtD;
        d_bundle.signimm      = SignImmD;
        d_bundle.pcplus4      = PCPlus4D;
        d_bundle.valid        = 1'b1;
    end

    // Conservative match: RsD/RtD are compared whether or not the
    // decode instruction actually reads them. A load into $0 never stalls.
    always_comb begin
        rt_hit  = (e_q.rt == RsD) | (e_q.rt == RtD);
        lwstall = e_q.valid & e_q.memtoreg &
                  (e_q.rt != '0) & rt_hit;
    end

    assign bubble = FlushE | lwstall;
    assign StallF = lwstall;
    assign StallD = lwstall;

    // A bubble clears the data fields too, so forwarding
    // comparisons in EX never match a squashed instruction.
    always_comb begin
        e_d = d_bundle;
        if (bubble) begin
            e_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    assign RegWriteE     = e_q.regwrite;
    assign MemtoRegE     = e_q.memtoreg;
    assign MemWriteE     = e_q.memwrite;
    assign BranchE       = e_q.branch;
    assign ALUControlE   = e_q.alucontrol;
    assign ALUSrcE       = e_q.alusrc;
    assign ALUSrc_shamtE = e_q.alusrc_shamt;
    assign RegDstE       = e_q.regdst;
    assign RD1E          = e_q.rd1;
    assign RD2E          = e_q.rd2;
    assign RsE           = e_q.rs;
    assign RtE           = e_q.rt;
    assign RdE           = e_q.rd;
    assign ShamtE        = e_q.shamt;
    assign SignImmE      = e_q.signimm;
    assign PCPlus4E      = e_q.pcplus4;
    assign ValidE        = e_q.valid;

`ifdef IDEX_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    // Counts load-use stalls only; flush-only bubbles are not counted.
    // Natural 32-bit wrap from all-ones back to zero.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else if (lwstall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vector table,
// async reset during a stall, then random stimulus against a reference model.

module tb_id_ex_stage_reg;

    localparam int DW = 32;
    localparam int RW = 5;

    typedef struct packed {
        logic          regw;
        logic          mtr;
        logic          mw;
        logic          br;
        logic [3:0]    alu;
        logic          alusrc;
        logic          alusrc_sh;
        logic          regdst;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [RW-1:0] shamt;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc4;
    } din_t;

    typedef struct packed {
        din_t c;
        logic valid;
    } e_t;

    typedef struct {
        din_t        d;
        logic        flush;
        logic        x_stall;
        logic        x_valid;
        logic        x_regw;
        logic        x_mtr;
        logic        x_mw;
        logic [3:0]  x_alu;
        logic [4:0]  x_rt;
        logic [31:0] x_rd1;
    } vec_t;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          RegWriteD, MemtoRegD, MemWriteD, BranchD;
    logic [3:0]    ALUControlD;
    logic          ALUSrcD, ALUSrc_shamtD, RegDstD;
    logic [DW-1:0] RD1D, RD2D, SignImmD, PCPlus4D;
    logic [RW-1:0] RsD, RtD, RdD, ShamtD;
    logic          FlushE;
    logic          RegWriteE, MemtoRegE, MemWriteE, BranchE;
    logic [3:0]    ALUControlE;
    logic          ALUSrcE, ALUSrc_shamtE, RegDstE;
    logic [DW-1:0] RD1E, RD2E, SignImmE, PCPlus4E;
    logic [RW-1:0] RsE, RtE, RdE, ShamtE;
    logic          ValidE, StallF, StallD;
`ifdef IDEX_STALL_COUNT_EN
    logic [31:0]   StallCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    id_ex_stage_reg #(.DW(DW), .RW(RW)) dut (
        .CLK(CLK), .Reset(Reset),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .BranchD(BranchD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
        .ALUSrc_shamtD(ALUSrc_shamtD), .RegDstD(RegDstD),
        .RD1D(RD1D), .RD2D(RD2D),
        .RsD(RsD), .RtD(RtD), .RdD(RdD), .ShamtD(ShamtD),
        .SignImmD(SignImmD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .ALUSrc_shamtE(ALUSrc_shamtE), .RegDstE(RegDstE),
        .RD1E(RD1E), .RD2E(RD2E),
        .RsE(RsE), .RtE(RtE), .RdE(RdE), .ShamtE(ShamtE),
        .SignImmE(SignImmE), .PCPlus4E(PCPlus4E),
        .ValidE(ValidE),
`ifdef IDEX_STALL_COUNT_EN
        .StallCount(StallCount),
`endif
        .StallF(StallF), .StallD(StallD)
    );

    e_t e_act;
    always_comb begin
        e_act = {RegWriteE, MemtoRegE, MemWriteE, BranchE,
                 ALUControlE, ALUSrcE, ALUSrc_shamtE, RegDstE,
                 RD1E, RD2E, RsE, RtE, RdE, ShamtE,
                 SignImmE, PCPlus4E, ValidE};
    end

    task automatic chk(input string nm, input logic [199:0] a,
                       input logic [199:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic apply(input din_t d, input logic f);
        RegWriteD     = d.regw;
        MemtoRegD     = d.mtr;
        MemWriteD     = d.mw;
        BranchD       = d.br;
        ALUControlD   = d.alu;
        ALUSrcD       = d.alusrc;
        ALUSrc_shamtD = d.alusrc_sh;
        RegDstD       = d.regdst;
        RD1D          = d.rd1;
        RD2D          = d.rd2;
        RsD           = d.rs;
        RtD           = d.rt;
        RdD           = d.rd;
        ShamtD        = d.shamt;
        SignImmD      = d.imm;
        PCPlus4D      = d.pc4;
        FlushE        = f;
    endtask

    function automatic din_t mkd(logic rw, logic mt, logic mw,
                                 logic [3:0] alu, logic as, logic rdst,
                                 logic [4:0] rs, logic [4:0] rt,
                                 logic [4:0] rd, logic [31:0] r1,
                                 logic [31:0] r2);
        din_t d = '0;
        d.regw = rw; d.mtr = mt; d.mw = mw; d.alu = alu;
        d.alusrc = as; d.regdst = rdst;
        d.rs = rs; d.rt = rt; d.rd = rd;
        d.rd1 = r1; d.rd2 = r2;
        return d;
    endfunction

    function automatic vec_t mkv(din_t d, logic f, logic s, logic v,
                                 logic rw, logic mt, logic mw,
                                 logic [3:0] alu, logic [4:0] rt,
                                 logic [31:0] r1);
        vec_t x;
        x.d = d; x.flush = f; x.x_stall = s; x.x_valid = v;
        x.x_regw = rw; x.x_mtr = mt; x.x_mw = mw;
        x.x_alu = alu; x.x_rt = rt; x.x_rd1 = r1;
        return x;
    endfunction

    function automatic din_t rand_d();
        din_t d;
        d.regw      = 1'($urandom);
        d.mtr       = 1'($urandom);
        d.mw        = 1'($urandom);
        d.br        = 1'($urandom);
        d.alu       = 4'($urandom);
        d.alusrc    = 1'($urandom);
        d.alusrc_sh = 1'($urandom);
        d.regdst    = 1'($urandom);
        d.rd1       = $urandom;
        d.rd2       = $urandom;
        d.rs        = 5'($urandom_range(0, 3));
        d.rt        = 5'($urandom_range(0, 3));
        d.rd        = 5'($urandom);
        d.shamt     = 5'($urandom);
        d.imm       = $urandom;
        d.pc4       = $urandom;
        return d;
    endfunction

    vec_t vt[13];
    e_t   m;
    logic m_stall;
    int   m_cnt;
    din_t rd_d;
    logic rd_f;

    initial begin
        vt[0]  = mkv(mkd(1,0,0,4'd2,0,1,5'd1,5'd2,5'd3,32'd5,32'd7), 0,
                     0,1,1,0,0,4'd2,5'd2,32'd5);
        vt[1]  = mkv(mkd(1,1,0,4'd2,1,0,5'd4,5'd8,5'd0,32'd100,32'd0), 0,
                     0,1,1,1,0,4'd2,5'd8,32'd100);
        vt[2]  = mkv(mkd(1,0,0,4'd2,0,1,5'd8,5'd9,5'd10,32'd11,32'd0), 0,
                     1,0,0,0,0,4'd0,5'd0,32'd0);
        vt[3]  = mkv(mkd(1,0,0,4'd2,0,1,5'd8,5'd9,5'd10,32'd11,32'd0), 0,
                     0,1,1,0,0,4'd2,5'd9,32'd11);
        vt[4]  = mkv(mkd(1,1,0,4'd2,1,0,5'd0,5'd0,5'd0,32'd20,32'd0), 0,
                     0,1,1,1,0,4'd2,5'd0,32'd20);
        vt[5]  = mkv(mkd(1,0,0,4'd2,0,1,5'd0,5'd0,5'd5,32'd21,32'd0), 0,
                     0,1,1,0,0,4'd2,5'd0,32'd21);
        vt[6]  = mkv(mkd(1,1,0,4'd2,1,0,5'd1,5'd8,5'd0,32'd30,32'd0), 0,
                     0,1,1,1,0,4'd2,5'd8,32'd30);
        vt[7]  = mkv(mkd(1,0,0,4'd6,0,1,5'd9,5'd10,5'd11,32'd31,32'd0), 0,
                     0,1,1,0,0,4'd6,5'd10,32'd31);
        vt[8]  = mkv(mkd(0,0,1,4'd2,1,0,5'd2,5'd3,5'd0,32'd40,32'd0), 1,
                     0,0,0,0,0,4'd0,5'd0,32'd0);
        vt[9]  = mkv(mkd(1,1,0,4'd2,1,0,5'd2,5'd8,5'd0,32'd50,32'd0), 0,
                     0,1,1,1,0,4'd2,5'd8,32'd50);
        vt[10] = mkv(mkd(1,0,0,4'd2,0,1,5'd3,5'd8,5'd4,32'd51,32'd0), 1,
                     1,0,0,0,0,4'd0,5'd0,32'd0);
        vt[11] = mkv(mkd(1,0,0,4'd2,0,1,5'd3,5'd8,5'd4,32'd51,32'd0), 0,
                     0,1,1,0,0,4'd2,5'd8,32'd51);
        vt[12] = mkv(mkd(0,0,0,4'd0,0,0,5'd12,5'd13,5'd14,32'd60,32'd0), 0,
                     0,1,0,0,0,4'd0,5'd13,32'd60);

        Reset = 1'b1;
        apply('0, 1'b0);
        #12;
        chk("reset_e", e_act, '0);
        chk("reset_stallf", StallF, 1'b0);
`ifdef IDEX_STALL_COUNT_EN
        chk("reset_cnt", StallCount, 32'd0);
`endif
        @(negedge CLK);
        Reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            apply(vt[i].d, vt[i].flush);
            #1;
            chk($sformatf("v%0d_stallf", i), StallF, vt[i].x_stall);
            chk($sformatf("v%0d_stalld", i), StallD, vt[i].x_stall);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_valid", i), ValidE, vt[i].x_valid);
            chk($sformatf("v%0d_regw", i), RegWriteE, vt[i].x_regw);
            chk($sformatf("v%0d_mtr", i), MemtoRegE, vt[i].x_mtr);
            chk($sformatf("v%0d_mw", i), MemWriteE, vt[i].x_mw);
            chk($sformatf("v%0d_alu", i), ALUControlE, vt[i].x_alu);
            chk($sformatf("v%0d_rt", i), RtE, vt[i].x_rt);
            chk($sformatf("v%0d_rd1", i), RD1E, vt[i].x_rd1);
            if (i == 0) begin
                chk("v0_rd2", RD2E, 32'd7);
                chk("v0_rd", RdE, 5'd3);
                chk("v0_regdst", RegDstE, 1'b1);
            end
        end
`ifdef IDEX_STALL_COUNT_EN
        chk("table_cnt", StallCount, 32'd2);
`endif

        // Async reset while a load-use stall is active.
        @(negedge CLK);
        apply(mkd(1,1,0,4'd2,1,0,5'd1,5'd8,5'd0,32'd70,32'd0), 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        apply(mkd(1,0,0,4'd2,0,1,5'd8,5'd2,5'd3,32'd71,32'd0), 1'b0);
        #1;
        chk("mid_stall_pre", StallF, 1'b1);
        #1;
        Reset = 1'b1;
        #1;
        chk("mid_reset_valid", ValidE, 1'b0);
        chk("mid_reset_mtr", MemtoRegE, 1'b0);
        chk("mid_reset_e", e_act, '0);
        chk("mid_reset_stallf", StallF, 1'b0);
        chk("mid_reset_stalld", StallD, 1'b0);
`ifdef IDEX_STALL_COUNT_EN
        chk("mid_reset_cnt", StallCount, 32'd0);
`endif
        @(negedge CLK);
        Reset = 1'b0;

        // Random phase against a spec-level model of the EX slot.
        m     = '0;
        m_cnt = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            rd_d = rand_d();
            rd_f = ($urandom_range(0, 7) == 0);
            apply(rd_d, rd_f);
            m_stall = m.valid && m.c.mtr && (m.c.rt != 0) &&
                      (m.c.rt == rd_d.rs || m.c.rt == rd_d.rt);
            #1;
            chk("rnd_stallf", StallF, m_stall);
            chk("rnd_stalld", StallD, m_stall);
            if (rd_f || m_stall) begin
                m = '0;
            end else begin
                m.c     = rd_d;
                m.valid = 1'b1;
            end
            if (m_stall) m_cnt++;
            @(posedge CLK);
            #1;
            chk("rnd_e", e_act, m);
        end
`ifdef IDEX_STALL_COUNT_EN
        chk("rnd_cnt", StallCount, 32'(m_cnt));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
